// File: rtl/wb_scheduler.sv
// Writeback scheduler: decodes Rd mux select, tracks one outstanding load and
// arbitrates the single register-file write port between loads and pipeline results.
module wb_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] rd_mux_out,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic [1:0]  rd_sel,
  output logic        ld_req,
  output logic [4:0]  ld_req_rd,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        ld_busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned SW   = 2;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_PEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pend_rd_q, pend_rd_d;

  logic            pend2_q;
  logic [AW-1:0]   addr2_q;
  logic            buf_full_q;
  logic [AW-1:0]   buf_addr_q;
  logic [XLEN-1:0] buf_data_q;

  logic            dec_wb;
  logic [SW-1:0]   dec_sel;
  logic            dec_load;
  logic            accept;
  logic            ld_ret;

  // Opcode decode into Rd mux select / load flag.
  always_comb begin
    dec_wb   = 1'b0;
    dec_sel  = 2'b00;
    dec_load = 1'b0;
    unique case (opcode)
      OP_JAL, OP_JALR: begin dec_wb = 1'b1; dec_sel = 2'b00; end
      OP_AUIPC:        begin dec_wb = 1'b1; dec_sel = 2'b01; end
      OP_LUI:          begin dec_wb = 1'b1; dec_sel = 2'b10; end
      OP_ALU, OP_ALUI: begin dec_wb = 1'b1; dec_sel = 2'b11; end
      OP_LOAD:         dec_load = 1'b1;
      default:         ;
    endcase
  end

  assign ld_ret = ld_valid && (state_q == LOAD_PEND);

  // Load-tracking FSM next state, issue stall and load request.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    stall     = 1'b0;
    accept    = 1'b0;
    ld_req    = 1'b0;
    ld_req_rd = '0;

    if (op_valid) begin
      if (state_q == LOAD_PEND &&
          (dec_load || rs1_addr == pend_rd_q || rs2_addr == pend_rd_q || rd_addr == pend_rd_q))
        stall = 1'b1;
      if (buf_full_q)
        stall = 1'b1;
      // A load return with S2 occupied fills the buffer, so hold issue.
      if (ld_ret && pend2_q)
        stall = 1'b1;
    end
    accept = op_valid && !stall;

    unique case (state_q)
      IDLE: begin
        if (accept && dec_load) begin
          ld_req    = 1'b1;
          ld_req_rd = rd_addr;
          if (rd_addr != '0) begin
            state_d   = LOAD_PEND;
            pend_rd_d = rd_addr;
          end
        end
      end
      LOAD_PEND: begin
        if (ld_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
    end
  end

  assign ld_busy = (state_q == LOAD_PEND);

  // S2 stage, skid buffer and write-port arbitration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend2_q    <= 1'b0;
      addr2_q    <= '0;
      rd_sel     <= 2'b00;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      pend2_q <= accept && dec_wb && (rd_addr != '0);
      if (accept && dec_wb && (rd_addr != '0)) begin
        addr2_q <= rd_addr;
        rd_sel  <= dec_sel;
      end

      wb_en <= 1'b0;
      if (ld_ret) begin
        wb_en   <= 1'b1;
        wb_addr <= pend_rd_q;
        wb_data <= ld_data;
      end else if (buf_full_q) begin
        wb_en   <= 1'b1;
        wb_addr <= buf_addr_q;
        wb_data <= buf_data_q;
      end else if (pend2_q) begin
        wb_en   <= 1'b1;
        wb_addr <= addr2_q;
        wb_data <= rd_mux_out;
      end

      // Buffer drains whenever no load return preempts it; S2 loser is captured.
      if (pend2_q && (ld_ret || buf_full_q)) begin
        buf_full_q <= 1'b1;
        buf_addr_q <= addr2_q;
        buf_data_q <= rd_mux_out;
      end else if (buf_full_q && !ld_ret) begin
        buf_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios then random traffic,
// all compared against a transaction-level reference model.
module tb_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] rd_mux_out;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [1:0]  rd_sel;
  logic        ld_req;
  logic [4:0]  ld_req_rd;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_scheduler dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_mux_out(rd_mux_out), .ld_valid(ld_valid), .ld_data(ld_data),
    .rd_sel(rd_sel), .ld_req(ld_req), .ld_req_rd(ld_req_rd), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ld_busy(ld_busy)
  );

  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, AUIPC = 7'b0010111,
                         LUI = 7'b0110111, ADD = 7'b0110011, ADDI = 7'b0010011,
                         LOAD = 7'b0000011, BR = 7'b1100011, ST = 7'b0100011,
                         SYS = 7'b1110011;

  // Reference model state: outstanding load, in-flight pipeline writes, last write.
  int          m_ld_rd;            // -1: no tracked load
  int          m_s2_rd;            // -1: no request one cycle after issue
  int          m_s2_sel;
  int          m_buf_rd;           // -1: nothing waiting for the port
  logic [31:0] m_buf_val;
  int          m_sel;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sel_of(input logic [6:0] op);
    case (op)
      JAL, JALR: return 0;
      AUIPC:     return 1;
      LUI:       return 2;
      ADD, ADDI: return 3;
      default:   return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_ld_rd = -1; m_s2_rd = -1; m_s2_sel = 0; m_buf_rd = -1; m_buf_val = '0;
    m_sel = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // One clock: drive inputs, check issue-side outputs, advance, check write port.
  task automatic step(input logic r, input logic v, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] mux, input logic lv, input logic [31:0] ld);
    bit   hazard, e_stall, acc, e_ldreq;
    bit   load_back;
    int   wq_rd;
    logic [31:0] wq_val;
    @(negedge clk);
    rst = r; op_valid = v; opcode = op; rd_addr = rd; rs1_addr = s1; rs2_addr = s2;
    rd_mux_out = mux; ld_valid = lv; ld_data = ld;
    #1;
    hazard  = (m_ld_rd >= 0) && (op == LOAD || int'(s1) == m_ld_rd ||
                                 int'(s2) == m_ld_rd || int'(rd) == m_ld_rd);
    load_back = lv && (m_ld_rd >= 0);
    e_stall = v && (hazard || m_buf_rd >= 0 || (load_back && m_s2_rd >= 0));
    acc     = v && !e_stall;
    e_ldreq = acc && (op == LOAD);
    check("stall", 32'(stall), 32'(e_stall));
    check("ld_req", 32'(ld_req), 32'(e_ldreq));
    if (e_ldreq) check("ld_req_rd", 32'(ld_req_rd), 32'(rd));

    if (!r) begin
      model_reset();
    end else begin
      // Contenders for the write port this cycle, in priority order.
      m_wen = 1'b0;
      wq_rd = -1; wq_val = '0;
      if (m_buf_rd >= 0) begin wq_rd = m_buf_rd; wq_val = m_buf_val; end
      if (m_s2_rd >= 0 && wq_rd < 0) begin wq_rd = m_s2_rd; wq_val = mux; end
      if (load_back) begin
        m_wen = 1'b1; m_waddr = 5'(m_ld_rd); m_wdata = ld;
        if (m_s2_rd >= 0) begin m_buf_rd = m_s2_rd; m_buf_val = mux; end
        m_ld_rd = -1;
      end else if (wq_rd >= 0) begin
        m_wen = 1'b1; m_waddr = 5'(wq_rd); m_wdata = wq_val;
        m_buf_rd = -1;
      end
      m_s2_rd = -1;
      if (acc && sel_of(op) >= 0 && rd != 0) begin
        m_s2_rd = int'(rd); m_sel = sel_of(op);
      end
      if (e_ldreq && rd != 0) m_ld_rd = int'(rd);
    end

    @(posedge clk);
    #1;
    check("wb_en", 32'(wb_en), 32'(m_wen));
    check("wb_addr", 32'(wb_addr), 32'(m_waddr));
    check("wb_data", wb_data, m_wdata);
    check("ld_busy", 32'(ld_busy), 32'(m_ld_rd >= 0));
    check("rd_sel", 32'(rd_sel), 32'(m_sel));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 7'h0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{JAL, JALR, AUIPC, LUI, ADD, ADDI, LOAD, BR, ST, SYS};
    model_reset();
    rst = 1'b0; op_valid = 1'b0; opcode = '0; rd_addr = '0; rs1_addr = '0;
    rs2_addr = '0; rd_mux_out = '0; ld_valid = 1'b0; ld_data = '0;

    step(0, 0, 7'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 7'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    check("reset_wb_en", 32'(wb_en), 32'h0);
    check("reset_ld_busy", 32'(ld_busy), 32'h0);

    // LUI rd=5.
    step(1, 1, LUI, 5, 0, 0, 32'h0, 0, 32'h0);
    check("lui_sel", 32'(rd_sel), 32'h2);
    step(1, 0, 7'h0, 0, 0, 0, 32'h12345000, 0, 32'h0);
    check("lui_wb", {wb_en, 3'b0, wb_addr, wb_data[23:0]}, {1'b1, 3'b0, 5'd5, 24'h345000});
    idle(1);

    // Load rd=7 and its return.
    step(1, 1, LOAD, 7, 1, 0, 32'h0, 0, 32'h0);
    check("load_busy", 32'(ld_busy), 32'h1);
    idle(2);
    step(1, 0, 7'h0, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF);
    check("load_wb", wb_data, 32'hDEADBEEF);
    check("load_busy_fall", 32'(ld_busy), 32'h0);

    // Load-use hazard on x3.
    step(1, 1, LOAD, 3, 0, 0, 32'h0, 0, 32'h0);
    step(1, 1, ADD, 6, 3, 2, 32'h0, 0, 32'h0);
    step(1, 1, ADD, 6, 3, 2, 32'h0, 0, 32'h0);
    step(1, 1, ADD, 6, 3, 2, 32'h0, 1, 32'h33);
    step(1, 1, ADD, 6, 3, 2, 32'h0, 0, 32'h0);
    step(1, 0, 7'h0, 0, 0, 0, 32'h6666, 0, 32'h0);
    check("use_wb", 32'(wb_addr), 32'h6);
    idle(1);

    // Collision: JAL rd=1 in S2 while load rd=9 returns.
    step(1, 1, LOAD, 9, 0, 0, 32'h0, 0, 32'h0);
    step(1, 1, JAL, 1, 0, 0, 32'h0, 0, 32'h0);
    step(1, 1, ADDI, 2, 0, 0, 32'h104, 1, 32'h99);
    check("coll_ld", 32'(wb_addr), 32'h9);
    step(1, 1, ADDI, 2, 0, 0, 32'h0, 0, 32'h0);
    check("coll_buf", wb_data, 32'h104);
    idle(3);

    // No writeback for rd=0 or store.
    step(1, 1, ADD, 0, 1, 2, 32'h0, 0, 32'h0);
    step(1, 1, ST, 4, 1, 2, 32'h55, 0, 32'h0);
    step(1, 0, 7'h0, 0, 0, 0, 32'h55, 0, 32'h0);
    check("nowb", 32'(wb_en), 32'h0);
    idle(1);

    // Reset with a load outstanding.
    step(1, 1, LOAD, 4, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 7'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 7'h0, 0, 0, 0, 32'h0, 1, 32'h44);
    check("rst_ld_drop", {wb_en, ld_busy, wb_addr}, 7'h0);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r, v, lv;
      logic [6:0]  op;
      r  = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ops[$urandom_range(0, 9)];
      lv = (m_ld_rd >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      step(r, v, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom, lv, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
